// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit on a req/gnt+rvalid bus; define MEM_MISALIGN_CHECK_EN to add misalignment trapping and MisalignM
module mem_stage_lsu #(
  parameter int RSP_TIMEOUT = 16,
  parameter int VEC_STRIDE  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] AluOutM,
  input  logic [31:0] StoreDataM,
  input  logic [3:0]  MemWriteM,
  input  logic        MemToRegM,
  input  logic [2:0]  RegWriteM,
  input  logic        MemWriteVecM,
  input  logic [63:0] VecRegWriteData,
  input  logic        ExtStallM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        StallMem,
  output logic [31:0] LoadDataM,
  output logic        LoadValidM,
  output logic        BusErrM
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic        MisalignM
`endif
);
  localparam int CW = $clog2(RSP_TIMEOUT);
  typedef enum logic [1:0] {IDLE, WAIT_RSP, VEC_HI, DONE} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc, is_vec, is_st, is_ld, mis, issue, timeout, fin;
  logic [31:0]   hi_addr, sh;
  // decode the held access (reset masks it) and detect completion this cycle
  always_comb begin
    acc    = rst_n & (MemToRegM | (|MemWriteM) | MemWriteVecM);
    is_vec = MemWriteVecM;
    is_st  = !MemWriteVecM & (|MemWriteM);
    is_ld  = !MemWriteVecM & !(|MemWriteM);
`ifdef MEM_MISALIGN_CHECK_EN
    mis = acc & (is_vec ? |AluOutM[1:0]
                        : is_ld & ((RegWriteM == 3'd3 & (|AluOutM[1:0]))
                                 | ((RegWriteM == 3'd2 | RegWriteM == 3'd5) & AluOutM[0])));
`else
    mis = 1'b0;
`endif
    issue   = state_q == IDLE & acc & !mis;
    timeout = state_q == WAIT_RSP & !bus_rvalid & cnt_q == CW'(RSP_TIMEOUT - 1);
    fin     = (state_q == IDLE & acc & (mis | (is_st & bus_gnt)))
            | (state_q == VEC_HI & bus_gnt)
            | (state_q == WAIT_RSP & (bus_rvalid | timeout));
  end
  // next state; DONE parks a finished access until the pipeline moves on
  always_comb begin
    state_d = fin                         ? (ExtStallM ? DONE : IDLE)
            : issue & bus_gnt             ? (is_vec ? VEC_HI : WAIT_RSP)
            : state_q == DONE & !ExtStallM ? IDLE
            : state_q;
    cnt_d   = state_q == WAIT_RSP ? cnt_q + 1'b1 : '0;
  end
  // state and response-timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // bus request fields, pipeline stall and load-data lane extraction
  always_comb begin
    hi_addr   = (AluOutM + 32'(VEC_STRIDE)) & 32'hFFFF_FFFC;
    bus_req   = issue | state_q == VEC_HI;
    bus_we    = bus_req & (state_q == VEC_HI | !is_ld);
    bus_addr  = !bus_req ? '0 : state_q == VEC_HI ? hi_addr : {AluOutM[31:2], 2'b00};
    bus_wdata = !bus_req ? '0 : state_q == VEC_HI ? VecRegWriteData[63:32]
              : is_vec ? VecRegWriteData[31:0] : is_st ? StoreDataM : '0;
    bus_wstrb = !bus_req ? '0 : (state_q == VEC_HI | is_vec) ? 4'hF : is_st ? MemWriteM : '0;
    StallMem  = ((state_q == IDLE & acc) | state_q == VEC_HI | state_q == WAIT_RSP) & !fin;
    sh        = (RegWriteM == 3'd1 | RegWriteM == 3'd4) ? bus_rdata >> {AluOutM[1:0], 3'b000}
              : (RegWriteM == 3'd2 | RegWriteM == 3'd5) ? bus_rdata >> {AluOutM[1], 4'b0000}
              : bus_rdata;
    LoadValidM = (state_q == WAIT_RSP & fin) | (mis & is_ld);
    BusErrM    = timeout;
    LoadDataM  = !(state_q == WAIT_RSP & bus_rvalid) ? '0
               : RegWriteM == 3'd1 ? {{24{sh[7]}}, sh[7:0]}
               : RegWriteM == 3'd2 ? {{16{sh[15]}}, sh[15:0]}
               : RegWriteM == 3'd4 ? {24'b0, sh[7:0]}
               : RegWriteM == 3'd5 ? {16'b0, sh[15:0]}
               : sh;
`ifdef MEM_MISALIGN_CHECK_EN
    MisalignM  = mis;
`endif
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized transaction-level bench for mem_stage_lsu
module tb_mem_stage_lsu;
  localparam int RSP_TIMEOUT = 16;
  localparam int VEC_STRIDE  = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] AluOutM, StoreDataM, bus_addr, bus_wdata, bus_rdata, LoadDataM;
  logic [3:0]  MemWriteM, bus_wstrb;
  logic [2:0]  RegWriteM;
  logic [63:0] VecRegWriteData;
  logic        MemToRegM, MemWriteVecM, ExtStallM, bus_req, bus_we, bus_gnt, bus_rvalid;
  logic        StallMem, LoadValidM, BusErrM;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        MisalignM;
`endif
  int checks = 0, errors = 0;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } beat_t;
  beat_t exp_q[$];
  always #5 clk = ~clk;
  mem_stage_lsu #(.RSP_TIMEOUT(RSP_TIMEOUT), .VEC_STRIDE(VEC_STRIDE)) dut (
    .clk(clk), .rst_n(rst_n), .AluOutM(AluOutM), .StoreDataM(StoreDataM),
    .MemWriteM(MemWriteM), .MemToRegM(MemToRegM), .RegWriteM(RegWriteM),
    .MemWriteVecM(MemWriteVecM), .VecRegWriteData(VecRegWriteData), .ExtStallM(ExtStallM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .StallMem(StallMem), .LoadDataM(LoadDataM), .LoadValidM(LoadValidM), .BusErrM(BusErrM)
`ifdef MEM_MISALIGN_CHECK_EN
    , .MisalignM(MisalignM)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] load_model(input logic [2:0] ty, input logic [31:0] a, input logic [31:0] rd);
    int bo = int'(a[1:0]);
    int ho = int'(a[1]);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*bo +: 8];
    h = rd[16*ho +: 16];
    case (ty)
      3'd1: return {{24{b[7]}}, b};
      3'd2: return {{16{h[15]}}, h};
      3'd4: return {24'b0, b};
      3'd5: return {16'b0, h};
      default: return rd;
    endcase
  endfunction
  function automatic logic mis_model(input int kind, input logic [2:0] ty, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
    if (kind == 2) return a[1:0] != 2'b00;
    if (kind == 0) return (ty == 3'd3 && a[1:0] != 2'b00) || ((ty == 3'd2 || ty == 3'd5) && a[0]);
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction
  task automatic idle_gap();
    @(negedge clk);
    ExtStallM = 1'b0; MemToRegM = 1'b0; MemWriteM = 4'h0; MemWriteVecM = 1'b0;
    bus_gnt = 1'($urandom); bus_rvalid = 1'($urandom); bus_rdata = $urandom;
    #1;
    check("gap_req", bus_req, 1'b0);
    check("gap_valid", LoadValidM, 1'b0);
  endtask
  // kind: 0 load, 1 scalar store, 2 vector store; rdly >= RSP_TIMEOUT means no response
  task automatic run_txn(input int kind, input logic [31:0] a, input logic [2:0] ty, input logic [3:0] strb,
                         input logic [31:0] sd, input logic [63:0] vd, input logic [31:0] rd,
                         input int gdly, input int rdly, input int hold);
    logic        mis;
    logic [31:0] ha;
    int          wait_g, wait_r, exp_cyc;
    bit          done;
    mis = mis_model(kind, ty, a);
    ha  = a + VEC_STRIDE;
    exp_q.delete();
    if (!mis) begin
      if (kind == 2) begin
        exp_q.push_back('{1'b1, {a[31:2], 2'b00}, vd[31:0], 4'hF});
        exp_q.push_back('{1'b1, {ha[31:2], 2'b00}, vd[63:32], 4'hF});
      end else if (kind == 1) exp_q.push_back('{1'b1, {a[31:2], 2'b00}, sd, strb});
      else exp_q.push_back('{1'b0, {a[31:2], 2'b00}, 32'h0, 4'h0});
    end
    exp_cyc = mis ? 0 : kind == 1 ? gdly : kind == 2 ? 2 * gdly + 1
            : gdly + 1 + (rdly < RSP_TIMEOUT ? rdly : RSP_TIMEOUT - 1);
    @(negedge clk);
    AluOutM = a; RegWriteM = ty; StoreDataM = sd; VecRegWriteData = vd;
    MemWriteVecM = kind == 2;
    MemWriteM = kind == 0 ? 4'h0 : kind == 1 ? strb : 4'($urandom);
    MemToRegM = kind == 0 ? 1'b1 : 1'($urandom);
    ExtStallM = hold > 0;
    wait_g = 0; wait_r = -1; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) @(negedge clk);
      bus_gnt    = 1'b0;
      bus_rvalid = wait_r < 0 ? 1'($urandom) : wait_r == rdly;
      bus_rdata  = wait_r == rdly ? rd : $urandom;
      #1;
      if (bus_req) begin
        if (exp_q.size() == 0) check("extra_req", bus_req, 1'b0);
        else begin
          check("we", bus_we, exp_q[0].we);
          check("addr", bus_addr, exp_q[0].addr);
          check("wstrb", bus_wstrb, exp_q[0].strb);
          if (exp_q[0].we) check("wdata", bus_wdata, exp_q[0].wdata);
          if (wait_g == gdly) begin
            bus_gnt = 1'b1;
            void'(exp_q.pop_front());
            wait_g = 0;
          end else wait_g++;
        end
      end
      #1;
      done = !StallMem;
      if (done) begin
        check("cycles", c, exp_cyc);
        check("valid", LoadValidM, kind == 0);
        check("buserr", BusErrM, kind == 0 && !mis && rdly >= RSP_TIMEOUT);
        if (kind == 0) check("ldata", LoadDataM, (!mis && rdly < RSP_TIMEOUT) ? load_model(ty, a, rd) : 32'h0);
        check("beats_left", exp_q.size(), 0);
`ifdef MEM_MISALIGN_CHECK_EN
        check("misalign", MisalignM, mis);
`endif
      end else begin
        check("early_valid", LoadValidM, 1'b0);
        check("early_err", BusErrM, 1'b0);
      end
      if (wait_r >= 0) wait_r++;
      if (bus_gnt && kind == 0) wait_r = 0;
    end
    if (!done) check("complete_timeout", 1'b0, 1'b1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus_gnt = 1'($urandom); bus_rvalid = 1'($urandom);
      #1;
      check("done_req", bus_req, 1'b0);
      check("done_stall", StallMem, 1'b0);
      check("done_valid", LoadValidM, 1'b0);
    end
    idle_gap();
  endtask
  initial begin
    AluOutM = 32'h0; StoreDataM = 32'h0; MemWriteM = 4'h0; MemToRegM = 1'b1; RegWriteM = 3'd3;
    MemWriteVecM = 1'b0; VecRegWriteData = 64'h0; ExtStallM = 1'b0;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", bus_req, 1'b0);
    check("rst_stall", StallMem, 1'b0);
    check("rst_valid", LoadValidM, 1'b0);
    check("rst_err", BusErrM, 1'b0);
    MemToRegM = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_gap();
    run_txn(0, 32'h100, 3'd3, 4'h0, 32'h0, 64'h0, 32'hDEADBEEF, 0, 1, 0);
    run_txn(0, 32'h103, 3'd1, 4'h0, 32'h0, 64'h0, 32'h80112233, 1, 0, 0);
    run_txn(0, 32'h103, 3'd4, 4'h0, 32'h0, 64'h0, 32'h80112233, 0, 2, 1);
    run_txn(0, 32'h102, 3'd5, 4'h0, 32'h0, 64'h0, 32'h80112233, 0, 0, 0);
    run_txn(2, 32'h200, 3'd0, 4'h0, 32'h0, 64'h11111111_22222222, 32'h0, 2, 0, 0);
    run_txn(1, 32'h100, 3'd0, 4'b0100, 32'h00AB0000, 64'h0, 32'h0, 0, 0, 3);
    run_txn(0, 32'h104, 3'd3, 4'h0, 32'h0, 64'h0, 32'h12345678, 0, 99, 0);
    run_txn(0, 32'h108, 3'd2, 4'h0, 32'h0, 64'h0, 32'h9876ABCD, 0, RSP_TIMEOUT - 1, 2);
    run_txn(0, 32'h102, 3'd3, 4'h0, 32'h0, 64'h0, 32'hCAFEF00D, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 2);
      run_txn(k, $urandom, 3'($urandom_range(1, 5)), 4'($urandom_range(1, 15)), $urandom,
              {$urandom, $urandom}, $urandom, $urandom_range(0, 3), $urandom_range(0, 20),
              $urandom_range(0, 3));
    end
    @(negedge clk);
    AluOutM = 32'h300; MemWriteVecM = 1'b1; VecRegWriteData = 64'hAAAA5555_12345678;
    ExtStallM = 1'b0; bus_gnt = 1'b1; bus_rvalid = 1'b0;
    #1;
    check("vrst_beat0", bus_req, 1'b1);
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    check("vrst_hi_req", bus_req, 1'b1);
    check("vrst_hi_addr", bus_addr, 32'h304);
    rst_n = 1'b0;
    #1;
    check("vrst_req", bus_req, 1'b0);
    check("vrst_stall", StallMem, 1'b0);
    @(negedge clk);
    MemWriteVecM = 1'b0;
    rst_n = 1'b1;
    #1;
    check("vrst_after", bus_req, 1'b0);
    idle_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
